// File: rtl/ntt_sequencer_pkg.sv
// Shared definitions for the NTT sequencer: arith-unit opcodes and FSM state encoding.
package ntt_sequencer_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_BFLY = 3'b011;
    localparam logic [2:0] OP_ROM  = 3'b100;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address map: (stage s, butterfly b) -> operand pair and twiddle index.
module ntt_addr_gen #(
    parameter int LOG_N = 3
) (
    input  logic [LOG_N-1:0] s,
    input  logic [LOG_N-1:0] b,
    output logic [LOG_N-1:0] addr_a,
    output logic [LOG_N-1:0] addr_b,
    output logic [LOG_N-1:0] tw_addr
);

    localparam logic [LOG_N-1:0] ONE    = LOG_N'(1);
    localparam logic [LOG_N-1:0] LAST_S = LOG_N'(LOG_N - 1);

    logic [LOG_N-1:0] m;
    logic [LOG_N-1:0] j;
    logic [LOG_N-1:0] g;

    // m is a power of two, so mod/div by m reduce to a mask and a shift.
    always_comb begin
        m       = ONE << s;
        j       = b & (m - ONE);
        g       = b >> s;
        addr_a  = (g << (s + ONE)) | j;
        addr_b  = addr_a + m;
        tw_addr = j << (LAST_S - s);
    end

endmodule

// File: rtl/ntt_sequencer.sv
// In-place radix-2 NTT sequencer: walks stages/butterflies as READ -> EXEC -> WRITE.
// Optional abort input enabled by defining NTT_SEQ_ABORT_EN.
module ntt_sequencer
    import ntt_sequencer_pkg::*;
#(
    parameter int LOG_N = 3,
    parameter int W     = 64
) (
    input  logic             clk,
    input  logic             rst,
`ifdef NTT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic [W-1:0]     cfg_q,
    input  logic [W-1:0]     cfg_mu,
    output logic [W-1:0]     op_q,
    output logic [W-1:0]     op_mu,
    output logic             rd_en,
    output logic [LOG_N-1:0] rd_addr_a,
    output logic [LOG_N-1:0] rd_addr_b,
    input  logic [W-1:0]     rd_data_a,
    input  logic [W-1:0]     rd_data_b,
    output logic             wr_en,
    output logic [LOG_N-1:0] wr_addr_a,
    output logic [LOG_N-1:0] wr_addr_b,
    output logic [W-1:0]     wr_data_a,
    output logic [W-1:0]     wr_data_b,
    output logic [2:0]       opcode,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    output logic [W-1:0]     op_w,
    input  logic [W-1:0]     res_in_1,
    input  logic [W-1:0]     res_in_2,
    output logic [LOG_N-1:0] tw_addr,
    input  logic [W-1:0]     tw_data
);

    localparam int               HALF   = (1 << LOG_N) / 2;
    localparam logic [LOG_N-1:0] LAST_S = LOG_N'(LOG_N - 1);
    localparam logic [LOG_N-1:0] LAST_B = LOG_N'(HALF - 1);

    state_e           state_q, state_d;
    logic [LOG_N-1:0] s_q, s_d;
    logic [LOG_N-1:0] b_q, b_d;
    logic [W-1:0]     mod_q_q, mod_q_d;
    logic [W-1:0]     mod_mu_q, mod_mu_d;
    logic [LOG_N-1:0] gen_addr_a, gen_addr_b, gen_tw;
    logic             abort_act;

`ifdef NTT_SEQ_ABORT_EN
    assign abort_act = abort;
`else
    assign abort_act = 1'b0;
`endif

    ntt_addr_gen #(.LOG_N(LOG_N)) u_addr_gen (
        .s       (s_q),
        .b       (b_q),
        .addr_a  (gen_addr_a),
        .addr_b  (gen_addr_b),
        .tw_addr (gen_tw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            s_q      <= '0;
            b_q      <= '0;
            mod_q_q  <= '0;
            mod_mu_q <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            b_q      <= b_d;
            mod_q_q  <= mod_q_d;
            mod_mu_q <= mod_mu_d;
        end
    end

    assign op_q  = mod_q_q;
    assign op_mu = mod_mu_q;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        b_d       = b_q;
        mod_q_d   = mod_q_q;
        mod_mu_d  = mod_mu_q;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        wr_en     = 1'b0;
        wr_addr_a = '0;
        wr_addr_b = '0;
        wr_data_a = '0;
        wr_data_b = '0;
        opcode    = OP_ADD;
        op_a      = '0;
        op_b      = '0;
        op_w      = '0;
        tw_addr   = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mod_q_d  = cfg_q;
                    mod_mu_d = cfg_mu;
                    s_d      = '0;
                    b_d      = '0;
                    state_d  = READ;
                end
            end
            READ: begin
                busy      = 1'b1;
                rd_en     = 1'b1;
                rd_addr_a = gen_addr_a;
                rd_addr_b = gen_addr_b;
                tw_addr   = gen_tw;
                state_d   = EXEC;
            end
            EXEC: begin
                busy    = 1'b1;
                opcode  = OP_BFLY;
                op_a    = rd_data_a;
                op_b    = rd_data_b;
                op_w    = tw_data;
                tw_addr = gen_tw;
                state_d = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                // A reset or abort arriving this cycle must not let the write land.
                wr_en     = ~rst & ~abort_act;
                wr_addr_a = gen_addr_a;
                wr_addr_b = gen_addr_b;
                wr_data_a = res_in_1;
                wr_data_b = res_in_2;
                if (s_q == LAST_S && b_q == LAST_B) begin
                    state_d = DONE;
                end else begin
                    state_d = READ;
                    if (b_q == LAST_B) begin
                        b_d = '0;
                        s_d = s_q + LOG_N'(1);
                    end else begin
                        b_d = b_q + LOG_N'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort_act && busy) begin
            state_d = IDLE;
        end
    end

endmodule

// File: doc/ntt_sequencer.md
NTT_SEQUENCER -- requirements
Module: ntt_sequencer

Interface
REQ-001 The block SHALL have parameter LOG_N, default 3, meaning log2 of transform size N (N = 1<<LOG_N).
REQ-002 The block SHALL have parameter W, default 64, meaning coefficient and modulus width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 The block SHALL have these control ports: start  in  1  launch transform; busy  out  1  transform in progress; done  out  1  one-cycle completion pulse.
REQ-005 The block SHALL have these modulus ports: cfg_q  in  W  modulus; cfg_mu  in  W  Barrett constant; op_q  out  W  latched modulus to arith unit; op_mu  out  W  latched mu to arith unit.
REQ-006 The block SHALL have these coefficient-memory read ports: rd_en  out  1  read strobe; rd_addr_a, rd_addr_b  out  LOG_N  read addresses; rd_data_a, rd_data_b  in  W  read data, valid one cycle after rd_en.
REQ-007 The block SHALL have these coefficient-memory write ports: wr_en  out  1  dual write strobe; wr_addr_a, wr_addr_b  out  LOG_N; wr_data_a, wr_data_b  out  W.
REQ-008 The block SHALL have these arith and twiddle ports: opcode  out  3; op_a, op_b, op_w  out  W; res_in_1, res_in_2  in  W  registered arith results; tw_addr  out  LOG_N; tw_data  in  W  combinational twiddle.

Function
REQ-009 The FSM SHALL have states IDLE, READ, EXEC, WRITE, DONE.
REQ-010 In IDLE with start=1, the FSM SHALL latch cfg_q/cfg_mu into op_q/op_mu, clear the counters, and go to READ.
REQ-011 In IDLE with start=0, the FSM SHALL remain in IDLE.
REQ-012 start SHALL be ignored in every state except IDLE, including DONE.
REQ-013 Each butterfly SHALL take three cycles: READ -> EXEC -> WRITE.
REQ-014 After WRITE, the FSM SHALL go to READ unless the last butterfly has been written, in which case it SHALL go to DONE.
REQ-015 DONE SHALL last one cycle and then go to IDLE.
REQ-016 Iteration order SHALL be: stage s = 0..LOG_N-1 outer; butterfly index b = 0..N/2-1 inner.
REQ-017 Addressing SHALL use m = 1<<s, j = b mod m, g = b / m: addr_a = 2*g*m + j; addr_b = addr_a + m; tw_addr = j << (LOG_N-1-s).
REQ-018 In READ, the block SHALL drive rd_en=1, rd_addr_a/b and tw_addr for the current butterfly.
REQ-019 In EXEC, the block SHALL drive opcode=3'b011 (butterfly), op_a=rd_data_a, op_b=rd_data_b, op_w=tw_data, and keep tw_addr stable.
REQ-020 In WRITE, the block SHALL drive wr_en=1, wr_addr_a/b equal to the READ addresses, wr_data_a=res_in_1 and wr_data_b=res_in_2.
REQ-021 Outside EXEC, the block SHALL drive opcode=3'b000 and op_a=op_b=op_w=0.
REQ-022 Outside READ, rd_en SHALL be 0; outside WRITE, wr_en SHALL be 0.
REQ-023 busy SHALL be 1 in READ, EXEC and WRITE, and 0 in IDLE and DONE.
REQ-024 done SHALL be 1 only in DONE.
REQ-025 With the start edge counted as cycle 0, done SHALL be high at cycle 3*(N/2)*LOG_N + 1 (cycle 37 for N=8).
REQ-026 op_q and op_mu SHALL hold the values latched at start for the whole run; changes on cfg_q/cfg_mu mid-run SHALL have no effect.
REQ-027 The b counter SHALL wrap to 0 and s SHALL increment when b = N/2-1 completes WRITE.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL go to IDLE and clear the counters; on the following cycle busy=0, done=0, rd_en=0, wr_en=0, opcode=0, all addresses 0, all data outputs 0, and op_q=op_mu=0.
REQ-029 Reset in any state, including WRITE, SHALL take priority over start and SHALL suppress any pending write.

Configuration
REQ-030 Macro NTT_SEQ_ABORT_EN SHALL control an abort feature.
REQ-031 With NTT_SEQ_ABORT_EN defined, the block SHALL have port abort (in, 1); abort=1 in READ, EXEC or WRITE SHALL force wr_en=0 that cycle and IDLE next cycle, with no done pulse.
REQ-032 With NTT_SEQ_ABORT_EN defined, abort SHALL be ignored in IDLE and DONE, and start and abort high together in IDLE SHALL give start priority.
REQ-033 Without NTT_SEQ_ABORT_EN defined, there SHALL be no abort port, and every started run SHALL complete.

Structure
REQ-034 A shared package SHALL hold the arith opcode constants (OP_ADD=3'b000, OP_MUL=3'b001, OP_SUB=3'b010, OP_BFLY=3'b011, OP_ROM=3'b100) and the FSM state encoding.
REQ-035 One sub-module, ntt_addr_gen, SHALL map (s, b) to addr_a, addr_b and tw_addr combinationally.

Verification
REQ-036 The bench SHALL cover: N=8, any q, start pulse -> done high exactly at cycle 37, busy high cycles 1..36, 12 wr_en pulses.
REQ-037 The bench SHALL cover: address trace -> stage0 pairs (0,1)(2,3)(4,5)(6,7) tw 0,0,0,0; stage1 (0,2)(1,3)(4,6)(5,7) tw 0,2,0,2; stage2 (0,4)(1,5)(2,6)(3,7) tw 0,1,2,3.
REQ-038 The bench SHALL cover: memory [1,0,0,0,0,0,0,0], q=17, real arith unit -> memory all 1 after done.
REQ-039 The bench SHALL cover: start held high through DONE -> no second run and busy=0 the cycle after DONE; cfg_q changed mid-run -> op_q unchanged.
REQ-040 The bench SHALL cover: rst asserted during the first WRITE of stage1 -> wr_en=0 from that edge on, IDLE and all outputs 0 next cycle, a new start then runs the full 37 cycles.
REQ-041 The bench SHALL cover, with NTT_SEQ_ABORT_EN defined: abort during an EXEC cycle -> no write for that butterfly, IDLE next cycle, no done pulse.
